alu_operand_stage: RTL and testbench

- ID/EX pipeline register that sits directly upstream of the 32-bit ALU.
- Each cycle it captures one decoded instruction and resolves data hazards by forwarding from the two younger-result sources.
- Decodes aluop/funct into the ALU's 4-bit control code.
- Presents registered operands a, b and the control code to the ALU, with valid/stall/flush pipeline control.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_ctl_decode.sv | 22 ++
 rtl/alu_operand_stage.sv | 88 ++++++++
 tb/tb_alu_operand_stage.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU control codes, aluop/funct encodings and forwarding-select enum
package alu_pkg;
    localparam logic [3:0] CTL_AND = 4'd0;
    localparam logic [3:0] CTL_OR  = 4'd1;
    localparam logic [3:0] CTL_ADD = 4'd2;
    localparam logic [3:0] CTL_SUB = 4'd6;
    localparam logic [3:0] CTL_NOR = 4'd12;
    localparam logic [3:0] CTL_XOR = 4'd13;
    localparam logic [3:0] CTL_NOP = 4'd15;
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;
    localparam logic [5:0] FUNCT_XOR = 6'b100110;
    typedef enum logic [1:0] {FWD_REG, FWD_EXM, FWD_WB, FWD_ZERO} fwd_sel_e;
endpackage

// File: rtl/alu_ctl_decode.sv
// alu_ctl_decode: combinational aluop/funct to 4-bit ALU control decode
// Ports: aluop, funct in; control (ALU code), illegal (unknown R-type funct) out.
module alu_ctl_decode import alu_pkg::*; (
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [3:0] control,
    output logic       illegal
);
    logic [3:0] r_ctl;
    always_comb begin
        r_ctl = funct == FUNCT_ADD ? CTL_ADD :
                funct == FUNCT_SUB ? CTL_SUB :
                funct == FUNCT_AND ? CTL_AND :
                funct == FUNCT_OR  ? CTL_OR  :
                funct == FUNCT_NOR ? CTL_NOR :
                funct == FUNCT_XOR ? CTL_XOR : CTL_NOP;
        control = aluop == ALUOP_ADD ? CTL_ADD :
                  aluop == ALUOP_SUB ? CTL_SUB :
                  aluop == ALUOP_OR  ? CTL_OR  : r_ctl;
        illegal = aluop == ALUOP_RTYPE && r_ctl == CTL_NOP;
    end
endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: ID/EX register feeding the ALU, with operand forwarding and control decode
// Ports: clk/rst; id_* decoded instruction; stall/flush pipeline control;
// exm_*/wb_* younger results for forwarding; ex_* registered ALU-side outputs.
module alu_operand_stage import alu_pkg::*; #(
    parameter int WIDTH  = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs_addr,
    input  logic [REG_AW-1:0] id_rt_addr,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic [WIDTH-1:0]  id_rs_data,
    input  logic [WIDTH-1:0]  id_rt_data,
    input  logic [WIDTH-1:0]  id_imm,
    input  logic [1:0]        id_aluop,
    input  logic [5:0]        id_funct,
    input  logic              id_alusrc,
    input  logic              id_regwrite,
    input  logic              stall,
    input  logic              flush,
    input  logic              exm_regwrite,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic [WIDTH-1:0]  exm_result,
    input  logic              wb_regwrite,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [WIDTH-1:0]  wb_result,
    output logic              ex_valid,
    output logic [WIDTH-1:0]  ex_a,
    output logic [WIDTH-1:0]  ex_b,
    output logic [WIDTH-1:0]  ex_store_data,
    output logic [3:0]        ex_control,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_regwrite,
    output logic              ex_illegal
);
    typedef struct packed {
        logic              valid;
        logic [WIDTH-1:0]  a;
        logic [WIDTH-1:0]  b;
        logic [WIDTH-1:0]  store_data;
        logic [3:0]        control;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              illegal;
    } stage_t;
    localparam stage_t BUBBLE = '{valid: 1'b0, a: '0, b: '0, store_data: '0, control: CTL_NOP,
                                  rd: '0, regwrite: 1'b0, illegal: 1'b0};
    stage_t     stage_d, stage_q, load;
    fwd_sel_e   sel_rs, sel_rt;
    logic [WIDTH-1:0] fwd_rs, fwd_rt;
    logic [3:0] dec_control;
    logic       dec_illegal;
    alu_ctl_decode u_dec (
        .aluop   (id_aluop),
        .funct   (id_funct),
        .control (dec_control),
        .illegal (dec_illegal)
    );
    always_comb begin
        // EX/MEM is younger than WB, so it is checked first
        sel_rs = id_rs_addr == '0 ? FWD_ZERO :
                 exm_regwrite && exm_rd == id_rs_addr ? FWD_EXM :
                 wb_regwrite && wb_rd == id_rs_addr ? FWD_WB : FWD_REG;
        sel_rt = id_rt_addr == '0 ? FWD_ZERO :
                 exm_regwrite && exm_rd == id_rt_addr ? FWD_EXM :
                 wb_regwrite && wb_rd == id_rt_addr ? FWD_WB : FWD_REG;
        fwd_rs = sel_rs == FWD_ZERO ? '0 : sel_rs == FWD_EXM ? exm_result :
                 sel_rs == FWD_WB ? wb_result : id_rs_data;
        fwd_rt = sel_rt == FWD_ZERO ? '0 : sel_rt == FWD_EXM ? exm_result :
                 sel_rt == FWD_WB ? wb_result : id_rt_data;
        load = '{valid: 1'b1, a: fwd_rs, b: id_alusrc ? id_imm : fwd_rt, store_data: fwd_rt,
                 control: dec_control, rd: id_rd_addr,
                 regwrite: id_regwrite && !dec_illegal && id_rd_addr != '0,
                 illegal: dec_illegal};
        stage_d = flush ? BUBBLE : stall ? stage_q : id_valid ? load : BUBBLE;
    end
    always_ff @(posedge clk) stage_q <= rst ? BUBBLE : stage_d;
    assign ex_valid      = stage_q.valid;
    assign ex_a          = stage_q.a;
    assign ex_b          = stage_q.b;
    assign ex_store_data = stage_q.store_data;
    assign ex_control    = stage_q.control;
    assign ex_rd         = stage_q.rd;
    assign ex_regwrite   = stage_q.regwrite;
    assign ex_illegal    = stage_q.illegal;
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: table vectors, hand sequences and random model check of alu_operand_stage
module tb_alu_operand_stage;
    typedef struct {
        logic        valid;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rs_data, rt_data, imm;
        logic [1:0]  aluop;
        logic [5:0]  funct;
        logic        alusrc, regwrite, stall, flush;
        logic        exm_regwrite;
        logic [4:0]  exm_rd;
        logic [31:0] exm_result;
        logic        wb_regwrite;
        logic [4:0]  wb_rd;
        logic [31:0] wb_result;
    } in_t;
    typedef struct packed {
        logic        valid;
        logic [31:0] a, b, sd;
        logic [3:0]  ctl;
        logic [4:0]  rd;
        logic        rw, ill;
    } out_t;
    typedef struct {
        string nm;
        in_t   in;
        out_t  exp;
    } vec_t;
    localparam out_t BUB = {1'b0, 96'd0, 4'hF, 5'd0, 2'b00};

    logic clk = 1'b0, rst = 1'b1;
    logic id_valid, id_alusrc, id_regwrite, stall, flush, exm_regwrite, wb_regwrite;
    logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr, exm_rd, wb_rd;
    logic [31:0] id_rs_data, id_rt_data, id_imm, exm_result, wb_result;
    logic [1:0]  id_aluop;
    logic [5:0]  id_funct;
    logic        ex_valid, ex_regwrite, ex_illegal;
    logic [31:0] ex_a, ex_b, ex_store_data;
    logic [3:0]  ex_control;
    logic [4:0]  ex_rd;

    int   n_cmp = 0, n_bad = 0;
    out_t mdl = BUB;
    vec_t tbl[$];
    vec_t v;
    in_t  ri, x;
    logic rr;
    logic [5:0] fn_tab [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h26};
    logic [3:0] ct_tab [6] = '{4'd2, 4'd6, 4'd0, 4'd1, 4'd12, 4'd13};

    alu_operand_stage #(.WIDTH(32), .REG_AW(5)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_aluop(id_aluop), .id_funct(id_funct), .id_alusrc(id_alusrc),
        .id_regwrite(id_regwrite), .stall(stall), .flush(flush),
        .exm_regwrite(exm_regwrite), .exm_rd(exm_rd), .exm_result(exm_result),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_result(wb_result),
        .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_store_data(ex_store_data),
        .ex_control(ex_control), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
        .ex_illegal(ex_illegal)
    );

    initial forever #5 clk = ~clk;

    function automatic in_t base();
        in_t i;
        i.valid = 1'b1; i.rs = 5'd3; i.rt = 5'd4; i.rd = 5'd5;
        i.rs_data = 32'hF0F0_0000; i.rt_data = 32'h0F0F_FFFF; i.imm = 32'h0000_1234;
        i.aluop = 2'b10; i.funct = 6'b100000; i.alusrc = 1'b0; i.regwrite = 1'b1;
        i.stall = 1'b0; i.flush = 1'b0;
        i.exm_regwrite = 1'b0; i.exm_rd = 5'd0; i.exm_result = 32'h0000_BAD0;
        i.wb_regwrite = 1'b0; i.wb_rd = 5'd0; i.wb_result = 32'h0000_BAD1;
        return i;
    endfunction

    function automatic out_t o(logic vl, logic [31:0] a, logic [31:0] b, logic [31:0] sd,
                               logic [3:0] c, logic [4:0] rd, logic rw, logic ill);
        return '{valid: vl, a: a, b: b, sd: sd, ctl: c, rd: rd, rw: rw, ill: ill};
    endfunction

    function automatic logic [31:0] fwd(logic [4:0] ad, logic [31:0] rf, in_t i);
        if (ad == 5'd0) return 32'd0;
        if (i.exm_regwrite && i.exm_rd == ad) return i.exm_result;
        if (i.wb_regwrite && i.wb_rd == ad) return i.wb_result;
        return rf;
    endfunction

    function automatic out_t model(out_t prev, in_t i, logic r);
        logic [31:0] ra, rb;
        logic [3:0]  c;
        logic        ill;
        if (r || i.flush) return BUB;
        if (i.stall) return prev;
        if (!i.valid) return BUB;
        ra = fwd(i.rs, i.rs_data, i);
        rb = fwd(i.rt, i.rt_data, i);
        c = 4'd15;
        case (i.aluop)
            2'b00: c = 4'd2;
            2'b01: c = 4'd6;
            2'b11: c = 4'd1;
            default: for (int k = 0; k < 6; k++) if (fn_tab[k] == i.funct) c = ct_tab[k];
        endcase
        ill = i.aluop == 2'b10 && c == 4'd15;
        return o(1'b1, ra, i.alusrc ? i.imm : rb, rb, c, i.rd,
                 i.regwrite && !ill && i.rd != 5'd0, ill);
    endfunction

    task automatic step(in_t i, logic r);
        rst = r; id_valid = i.valid; id_rs_addr = i.rs; id_rt_addr = i.rt; id_rd_addr = i.rd;
        id_rs_data = i.rs_data; id_rt_data = i.rt_data; id_imm = i.imm; id_aluop = i.aluop;
        id_funct = i.funct; id_alusrc = i.alusrc; id_regwrite = i.regwrite;
        stall = i.stall; flush = i.flush;
        exm_regwrite = i.exm_regwrite; exm_rd = i.exm_rd; exm_result = i.exm_result;
        wb_regwrite = i.wb_regwrite; wb_rd = i.wb_rd; wb_result = i.wb_result;
        @(posedge clk);
        #1;
        mdl = model(mdl, i, r);
    endtask

    task automatic chk1(string nm, string f, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got %h want %h", nm, f, act, exp);
        end
    endtask

    task automatic check(string nm, out_t e);
        chk1(nm, "valid", 32'(ex_valid), 32'(e.valid));
        chk1(nm, "a", ex_a, e.a);
        chk1(nm, "b", ex_b, e.b);
        chk1(nm, "store_data", ex_store_data, e.sd);
        chk1(nm, "control", 32'(ex_control), 32'(e.ctl));
        chk1(nm, "rd", 32'(ex_rd), 32'(e.rd));
        chk1(nm, "regwrite", 32'(ex_regwrite), 32'(e.rw));
        chk1(nm, "illegal", 32'(ex_illegal), 32'(e.ill));
    endtask

    initial begin
        // R-type decode of every legal funct plus one illegal
        for (int k = 0; k < 6; k++) begin
            v.nm = $sformatf("rtype%0d", k); v.in = base(); v.in.funct = fn_tab[k];
            v.exp = o(1'b1, 32'hF0F0_0000, 32'h0F0F_FFFF, 32'h0F0F_FFFF, ct_tab[k], 5'd5, 1'b1, 1'b0);
            tbl.push_back(v);
        end
        v.nm = "illegal"; v.in = base(); v.in.funct = 6'b000000;
        v.exp = o(1'b1, 32'hF0F0_0000, 32'h0F0F_FFFF, 32'h0F0F_FFFF, 4'd15, 5'd5, 1'b0, 1'b1);
        tbl.push_back(v);
        v.nm = "aluop_sub"; v.in = base(); v.in.aluop = 2'b01; v.in.funct = 6'b000000;
        v.exp = o(1'b1, 32'hF0F0_0000, 32'h0F0F_FFFF, 32'h0F0F_FFFF, 4'd6, 5'd5, 1'b1, 1'b0);
        tbl.push_back(v);
        v.nm = "aluop_or"; v.in = base(); v.in.aluop = 2'b11;
        v.exp = o(1'b1, 32'hF0F0_0000, 32'h0F0F_FFFF, 32'h0F0F_FFFF, 4'd1, 5'd5, 1'b1, 1'b0);
        tbl.push_back(v);
        // forwarding priority
        v.nm = "fwd_exm"; v.in = base(); v.in.rs = 5'd7; v.in.rt = 5'd7;
        v.in.exm_regwrite = 1'b1; v.in.exm_rd = 5'd7; v.in.exm_result = 32'h11;
        v.in.wb_regwrite = 1'b1; v.in.wb_rd = 5'd7; v.in.wb_result = 32'h22;
        v.exp = o(1'b1, 32'h11, 32'h11, 32'h11, 4'd2, 5'd5, 1'b1, 1'b0);
        tbl.push_back(v);
        v.nm = "fwd_wb"; v.in.exm_regwrite = 1'b0;
        v.exp = o(1'b1, 32'h22, 32'h22, 32'h22, 4'd2, 5'd5, 1'b1, 1'b0);
        tbl.push_back(v);
        v.nm = "fwd_zero"; v.in.rs = 5'd0; v.in.rs_data = 32'hDEAD_BEEF;
        v.in.exm_regwrite = 1'b1; v.in.exm_rd = 5'd0;
        v.exp = o(1'b1, 32'h0, 32'h22, 32'h22, 4'd2, 5'd5, 1'b1, 1'b0);
        tbl.push_back(v);
        // immediate path
        v.nm = "imm"; v.in = base(); v.in.aluop = 2'b00; v.in.alusrc = 1'b1;
        v.in.funct = 6'b000000; v.in.imm = 32'hFFFF_FFFC;
        v.in.wb_regwrite = 1'b1; v.in.wb_rd = 5'd4; v.in.wb_result = 32'h55;
        v.exp = o(1'b1, 32'hF0F0_0000, 32'hFFFF_FFFC, 32'h55, 4'd2, 5'd5, 1'b1, 1'b0);
        tbl.push_back(v);
        v.nm = "rd_zero"; v.in = base(); v.in.rd = 5'd0;
        v.exp = o(1'b1, 32'hF0F0_0000, 32'h0F0F_FFFF, 32'h0F0F_FFFF, 4'd2, 5'd0, 1'b0, 1'b0);
        tbl.push_back(v);
        v.nm = "invalid"; v.in = base(); v.in.valid = 1'b0; v.exp = BUB;
        tbl.push_back(v);

        // reset with a valid instruction presented, then first load
        step(base(), 1'b1); check("reset1", BUB);
        step(base(), 1'b1); check("reset2", BUB);
        step(base(), 1'b0);
        check("first_load", o(1'b1, 32'hF0F0_0000, 32'h0F0F_FFFF, 32'h0F0F_FFFF, 4'd2, 5'd5, 1'b1, 1'b0));

        foreach (tbl[n]) begin
            step(tbl[n].in, 1'b0);
            check(tbl[n].nm, tbl[n].exp);
        end

        // stall holds, stall+flush bubbles, release loads the new instruction
        x = base(); x.funct = 6'b100101;
        step(x, 1'b0);
        check("stall_load", o(1'b1, 32'hF0F0_0000, 32'h0F0F_FFFF, 32'h0F0F_FFFF, 4'd1, 5'd5, 1'b1, 1'b0));
        x.funct = 6'b100010; x.rs_data = 32'h0000_AAAA; x.rd = 5'd9; x.stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(x, 1'b0);
            check($sformatf("stall_hold%0d", k),
                  o(1'b1, 32'hF0F0_0000, 32'h0F0F_FFFF, 32'h0F0F_FFFF, 4'd1, 5'd5, 1'b1, 1'b0));
        end
        x.flush = 1'b1;
        step(x, 1'b0); check("stall_flush", BUB);
        x.stall = 1'b0; x.flush = 1'b0;
        step(x, 1'b0);
        check("resume", o(1'b1, 32'h0000_AAAA, 32'h0F0F_FFFF, 32'h0F0F_FFFF, 4'd6, 5'd9, 1'b1, 1'b0));
        // reset beats stall
        x.stall = 1'b1;
        step(x, 1'b1); check("rst_over_stall", BUB);

        // random traffic against the behavioural model
        for (int k = 0; k < 500; k++) begin
            ri.valid = $urandom_range(0, 7) != 0;
            ri.rs = 5'($urandom_range(0, 3)); ri.rt = 5'($urandom_range(0, 3));
            ri.rd = 5'($urandom_range(0, 3));
            ri.rs_data = $urandom; ri.rt_data = $urandom; ri.imm = $urandom;
            ri.aluop = 2'($urandom_range(0, 3));
            ri.funct = $urandom_range(0, 3) == 0 ? 6'($urandom) : fn_tab[$urandom_range(0, 5)];
            ri.alusrc = 1'($urandom_range(0, 1)); ri.regwrite = 1'($urandom_range(0, 1));
            ri.stall = $urandom_range(0, 4) == 0; ri.flush = $urandom_range(0, 9) == 0;
            ri.exm_regwrite = 1'($urandom_range(0, 1)); ri.exm_rd = 5'($urandom_range(0, 3));
            ri.exm_result = $urandom;
            ri.wb_regwrite = 1'($urandom_range(0, 1)); ri.wb_rd = 5'($urandom_range(0, 3));
            ri.wb_result = $urandom;
            rr = $urandom_range(0, 49) == 0;
            step(ri, rr);
            check($sformatf("rand%0d", k), mdl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
